// File: rtl/ram_reader_pkg.sv
// Shared definitions for the ram reader: FSM encoding, output FIFO depth
// and derived widths, reusable by future ram writer/arbiter blocks.
package ram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FDEPTH = 4;
  localparam int PW     = $clog2(FDEPTH);  // FIFO pointer width
  localparam int CW     = PW + 1;          // FIFO count width, holds 0..FDEPTH
  localparam int LW     = CW + 1;          // count + reads still in the ram pipe

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(FDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

endpackage

// File: rtl/ram_reader_if.sv
// Bundle of the ram reader's control, ram-port and stream signals, plus the
// FSM state and pipeline occupancy exposed for observation.
interface ram_reader_if
  import ram_reader_pkg::*;
#(
  parameter int AWID = 8,
  parameter int DWID = 16
);
  logic            i_start;
  logic [AWID-1:0] i_base;
  logic [AWID:0]   i_len;
  logic            o_busy;
  logic            o_done;

  logic            o_ram_we;
  logic [AWID-1:0] o_ram_addr;
  logic [DWID-1:0] i_ram_dat;

  // Stream handshake: a word moves on every posedge where o_valid & i_ready.
  // Once o_valid is high it stays high, with o_dat/o_last frozen, until that
  // transfer happens; i_ready may change freely and never gates o_valid.
  logic            o_valid;
  logic [DWID-1:0] o_dat;
  logic            o_last;
  logic            i_ready;

  state_t          fsm_state;
  logic [LW-1:0]   fifo_level;

  modport master (
    input  i_start, i_base, i_len, i_ram_dat, i_ready,
    output o_busy, o_done, o_ram_we, o_ram_addr, o_valid, o_dat, o_last,
    output fsm_state, fifo_level
  );

  modport slave (
    output i_start, i_base, i_len, i_ram_dat, i_ready,
    input  o_busy, o_done, o_ram_we, o_ram_addr, o_valid, o_dat, o_last,
    input  fsm_state, fifo_level
  );
endinterface

// File: rtl/ram_reader_fifo.sv
// Small synchronous FIFO holding ram words with their end-of-transfer flag.
// Simultaneous push and pop are both honoured; head is the oldest entry.
module ram_reader_fifo
  import ram_reader_pkg::*;
#(
  parameter int W = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem [FDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // The reader's issue throttle must make this unreachable.
      assert (!(push && !pop && count == CW'(FDEPTH)))
        else $error("ram_reader_fifo overflow");
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ram_reader.sv
// Read initiator for a 1-clock-latency synchronous ram: issues sequential
// reads from a base address and streams the words out through a small FIFO.
module ram_reader
  import ram_reader_pkg::*;
#(
  parameter int AWID = 8,
  parameter int DWID = 16
) (
  input logic         clk,
  input logic         rst_n,
  ram_reader_if.master bus
);

  localparam logic [AWID:0] ONE = (AWID + 1)'(1);

  state_t          state;
  logic            busy;
  logic            done;
  logic [AWID-1:0] addr;
  logic [AWID-1:0] base_q;
  logic [AWID:0]   len_q;
  logic [AWID:0]   issued;
  // rd1: address presented to the ram; rd2: its data is on i_ram_dat.
  logic            rd1;
  logic            rd2;
  logic            last1;
  logic            last2;

  logic            issue;
  logic            push;
  logic            pop;
  logic            valid;
  logic [CW-1:0]   count;
  logic [DWID:0]   head;
  logic [LW-1:0]   level;

  // Reads in the ram pipe are counted so FIFO space is reserved before issue.
  assign level = LW'(count) + LW'(rd1) + LW'(rd2);
  assign issue = (state == RUN) && (issued < len_q) && (level < LW'(FDEPTH));
  assign push  = rd2;
  assign valid = (count != '0);
  assign pop   = valid & bus.i_ready;

  ram_reader_fifo #(.W(DWID + 1)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({last2, bus.i_ram_dat}),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      addr   <= '0;
      base_q <= '0;
      len_q  <= '0;
      issued <= '0;
      rd1    <= 1'b0;
      rd2    <= 1'b0;
      last1  <= 1'b0;
      last2  <= 1'b0;
    end else begin
      rd1   <= issue;
      rd2   <= rd1;
      last1 <= issue && (issued == len_q - ONE);
      last2 <= last1;
      done  <= 1'b0;
      if (issue) begin
        addr   <= base_q + issued[AWID-1:0];
        issued <= issued + ONE;
      end
      case (state)
        IDLE, DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (bus.i_start) begin
            base_q <= bus.i_base;
            len_q  <= bus.i_len;
            issued <= '0;
            if (bus.i_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (pop && head[DWID] && issued == len_q) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_busy     = busy;
  assign bus.o_done     = done;
  assign bus.o_ram_we   = 1'b0;
  assign bus.o_ram_addr = addr;
  assign bus.o_valid    = valid;
  assign bus.o_dat      = valid ? head[DWID-1:0] : '0;
  assign bus.o_last     = valid & head[DWID];
  assign bus.fsm_state  = state;
  assign bus.fifo_level = level;

endmodule

// File: tb/tb_ram_reader.sv
// Bench for ram_reader: behavioural ram preloaded with A000+i, directed and
// randomized transfers, scoreboard of expected {last, data} words.
module tb_ram_reader;
  import ram_reader_pkg::*;

  localparam int AWID = 8;
  localparam int DWID = 16;
  localparam time T   = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_reader_if #(.AWID(AWID), .DWID(DWID)) bus ();

  ram_reader #(.AWID(AWID), .DWID(DWID)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ram model
  logic [DWID-1:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
  always @(posedge clk) bus.i_ram_dat <= mem[bus.o_ram_addr];

  int total = 0;
  int bad   = 0;
  logic [DWID:0] exp_q[$];
  int  rx_cnt = 0;
  time t_first = 0;
  time t_last  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // ready driver: 0 = always ready, 1 = fixed toggle pattern, 2 = random
  int rmode = 0;
  int rstep = 0;
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  initial begin
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1: begin
          bus.i_ready = pat[rstep % 6];
          rstep++;
        end
        2:       bus.i_ready = 1'($urandom_range(0, 1));
        default: bus.i_ready = 1'b1;
      endcase
    end
  end

  // monitor / scoreboard
  logic            pv = 1'b0;
  logic            pr = 1'b0;
  logic            pl = 1'b0;
  logic [DWID-1:0] pd = '0;
  always @(negedge clk) begin
    logic [DWID:0] e;
    check("ram_we_zero", 32'(bus.o_ram_we), 32'd0);
    if (rst_n) begin
      check("level_le_depth", 32'(bus.fifo_level <= LW'(FDEPTH)), 32'd1);
      if (pv && !pr) begin
        check("stall_valid", 32'(bus.o_valid), 32'd1);
        check("stall_dat", 32'(bus.o_dat), 32'(pd));
        check("stall_last", 32'(bus.o_last), 32'(pl));
      end
      if (bus.o_valid && bus.i_ready) begin
        check("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("word_dat", 32'(bus.o_dat), 32'(e[DWID-1:0]));
          check("word_last", 32'(bus.o_last), 32'(e[DWID]));
        end
        if (rx_cnt == 0) t_first = $time;
        if (bus.o_last) t_last = $time;
        rx_cnt++;
      end
      pv = bus.o_valid;
      pr = bus.i_ready;
      pd = bus.o_dat;
      pl = bus.o_last;
    end else begin
      pv = 1'b0;
    end
  end

  // Drive a start request sampled by the next posedge; queue the expected words.
  task automatic launch(input logic [AWID-1:0] b, input logic [AWID:0] n);
    logic [DWID:0] w;
    for (int k = 0; k < int'(n); k++) begin
      w[DWID]     = (k == int'(n) - 1);
      w[DWID-1:0] = 16'hA000 + 16'((int'(b) + k) % 256);
      exp_q.push_back(w);
    end
    rx_cnt      = 0;
    bus.i_base  = b;
    bus.i_len   = n;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
  endtask

  // Wait (bounded) for o_done; returns at the negedge where it is seen.
  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    @(negedge clk);
    while (bus.o_done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, 32'(bus.o_done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(bus.o_busy), 32'd0);
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_done_after_last"}, 32'($time - t_last), 32'(T));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AWID-1:0] b;
    logic [AWID-1:0] a0;
    logic [AWID-1:0] ea;
    logic [AWID:0]   n;
    int              k;

    bus.i_start = 1'b0;
    bus.i_base  = '0;
    bus.i_len   = '0;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_done", 32'(bus.o_done), 32'd0);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_dat", 32'(bus.o_dat), 32'd0);
    check("rst_last", 32'(bus.o_last), 32'd0);
    check("rst_addr", 32'(bus.o_ram_addr), 32'd0);
    check("rst_state", 32'(bus.fsm_state), 32'(IDLE));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: base 0, len 8, always ready; latency and burst shape
    rmode = 0;
    launch(8'h00, 9'd8);
    @(negedge clk);
    check("t1_busy", 32'(bus.o_busy), 32'd1);
    check("t1_valid_c0", 32'(bus.o_valid), 32'd0);
    @(negedge clk);
    check("t1_addr_first", 32'(bus.o_ram_addr), 32'd0);
    @(negedge clk);
    check("t1_valid_c2", 32'(bus.o_valid), 32'd0);
    @(negedge clk);
    check("t1_valid_c3", 32'(bus.o_valid), 32'd1);
    check("t1_first_dat", 32'(bus.o_dat), 32'h0000A000);
    wait_done("t1", 100);
    check("t1_burst_span", 32'(t_last - t_first), 32'(7 * T));

    // 2: address wrap FE,FF,00,01
    launch(8'hFE, 9'd4);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ea = 8'hFE + 8'(i);
      check("t2_addr_seq", 32'(bus.o_ram_addr), 32'(ea));
    end
    wait_done("t2", 100);

    // 3: toggling backpressure
    rmode = 1;
    rstep = 0;
    launch(8'($urandom_range(0, 255)), 9'd6);
    wait_done("t3", 200);
    rmode = 0;

    // 4: zero length
    a0 = bus.o_ram_addr;
    launch(8'($urandom_range(0, 255)), 9'd0);
    @(negedge clk);
    check("t4_done_pulse", 32'(bus.o_done), 32'd1);
    check("t4_busy", 32'(bus.o_busy), 32'd0);
    check("t4_valid", 32'(bus.o_valid), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("t4_done_clear", 32'(bus.o_done), 32'd0);
      check("t4_valid_idle", 32'(bus.o_valid), 32'd0);
      check("t4_addr_hold", 32'(bus.o_ram_addr), 32'(a0));
    end

    // 5: restart ignored while busy, accepted in the done clock
    b = 8'($urandom_range(0, 255));
    launch(b, 9'd12);
    repeat (4) @(negedge clk);
    bus.i_base  = b + 8'd100;
    bus.i_len   = 9'd3;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    @(negedge clk);
    check("t5_busy_kept", 32'(bus.o_busy), 32'd1);
    wait_done("t5a", 200);
    launch(8'($urandom_range(0, 255)), 9'd5);
    @(negedge clk);
    check("t5_restart_busy", 32'(bus.o_busy), 32'd1);
    check("t5_restart_done", 32'(bus.o_done), 32'd0);
    wait_done("t5b", 200);

    // 6: reset after three words of a ten-word transfer
    launch(8'($urandom_range(0, 255)), 9'd10);
    k = 0;
    while (rx_cnt < 3 && k < 100) begin
      @(posedge clk);
      k++;
    end
    check("t6_three_words", 32'(rx_cnt), 32'd3);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("t6_valid", 32'(bus.o_valid), 32'd0);
    check("t6_busy", 32'(bus.o_busy), 32'd0);
    check("t6_done", 32'(bus.o_done), 32'd0);
    check("t6_dat", 32'(bus.o_dat), 32'd0);
    repeat (5) begin
      @(negedge clk);
      check("t6_no_done", 32'(bus.o_done), 32'd0);
      check("t6_no_valid", 32'(bus.o_valid), 32'd0);
    end
    launch(8'($urandom_range(0, 255)), 9'd2);
    wait_done("t6", 100);

    // randomized transfers under random backpressure
    for (int r = 0; r < 5; r++) begin
      rmode = 2;
      n = 9'($urandom_range(1, 20));
      launch(8'($urandom_range(0, 255)), n);
      wait_done("rand", 500);
    end

    // full address space, wrapping
    rmode = 0;
    launch(8'($urandom_range(0, 255)), 9'd256);
    wait_done("full", 600);
    check("full_burst_span", 32'(t_last - t_first), 32'(255 * T));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
